// File: rtl/xfcp_udp_pkg.sv
// Shared constants, FSM state type and checksum helper for the XFCP-over-UDP framer.
package xfcp_udp_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam int          ETH_HDR_LEN   = 14;
    localparam int          IP_HDR_LEN    = 20;
    localparam int          UDP_HDR_LEN   = 8;
    localparam int          MIN_FRAME_LEN = 60;
    localparam int          HDR_LEN       = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_DROP,
        ST_CKSUM,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD
    } tx_state_e;

    // One ones-complement fold: add the carry half back into the low 16 bits.
    function automatic logic [31:0] ones_fold(input logic [31:0] s);
        return {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    endfunction

endpackage

// File: rtl/xfcp_udp_tx_framer_if.sv
// 8-bit byte stream with last/user sidebands, used for both XFCP input and Ethernet output.
interface xfcp_udp_tx_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/xfcp_udp_tx_buf.sv
// Simple dual-port byte RAM with a registered read port, holding one payload.
module xfcp_udp_tx_buf #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; every location is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/xfcp_udp_tx_framer.sv
// Buffers one XFCP response packet, then emits it as an Ethernet II / IPv4 / UDP frame (no FCS).
module xfcp_udp_tx_framer
    import xfcp_udp_pkg::*;
#(
    parameter int BUF_ADDR_WIDTH = 11,
    parameter int MAX_PAYLOAD    = 1472,
    parameter int TTL            = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    xfcp_udp_tx_framer_if.slave         s_xfcp,
    xfcp_udp_tx_framer_if.master        m_eth_axis,
    input  logic [47:0]                 local_mac,
    input  logic [31:0]                 local_ip,
    input  logic [15:0]                 local_port,
    input  logic [47:0]                 remote_mac,
    input  logic [31:0]                 remote_ip,
    input  logic [15:0]                 remote_port,
    input  logic                        remote_valid,
    output logic                        busy,
    output logic                        err_oversize,
    output logic                        err_bad
);

    localparam logic [10:0] MAX_LEN    = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LEN_L  = 11'(HDR_LEN);
    localparam logic [10:0] PAD_BELOW  = 11'(MIN_FRAME_LEN - HDR_LEN);
    localparam logic [10:0] MIN_LAST   = 11'(MIN_FRAME_LEN - 1);

    tx_state_e state_q, state_d;

    logic        run_q;
    logic [10:0] len_q;
    logic [10:0] pos_q;
    logic [15:0] ip_id_q;
    logic [31:0] sum_q;
    logic [15:0] csum_q;
    logic        cks_step_q;

    logic [47:0] rmac_q, lmac_q;
    logic [31:0] rip_q, lip_q;
    logic [15:0] rport_q, lport_q;

    logic        in_fire, out_fire;
    logic        s_ready, m_valid, m_last;
    logic [7:0]  m_data;
    logic        take_snapshot, bad_d, over_d;
    logic [10:0] len_inc, wr_index;
    logic [10:0] payload_last, frame_last, pos_next;
    logic [15:0] ip_len, udp_len;
    logic [7:0]  rd_data, hdr_byte;
    logic [5:0]  hdr_idx;
    logic [HDR_LEN*8-1:0] hdr;

    assign in_fire  = s_xfcp.tvalid && s_ready;
    assign out_fire = m_valid && m_eth_axis.tready;

    // First byte of a packet lands at address 0; the count saturates instead of wrapping.
    assign wr_index = (state_q == ST_IDLE) ? 11'd0 : len_q;
    assign len_inc  = (state_q == ST_IDLE) ? 11'd1
                    : (len_q == 11'h7FF)   ? len_q : len_q + 11'd1;

    assign ip_len       = 16'(IP_HDR_LEN + UDP_HDR_LEN) + {5'b0, len_q};
    assign udp_len      = 16'(UDP_HDR_LEN) + {5'b0, len_q};
    assign payload_last = HDR_LEN_L + len_q - 11'd1;
    assign frame_last   = (len_q < PAD_BELOW) ? MIN_LAST : payload_last;

    assign hdr = {rmac_q, lmac_q, ETH_TYPE_IPV4,
                  8'h45, 8'h00, ip_len, ip_id_q, 16'h4000, 8'(TTL), IP_PROTO_UDP, csum_q,
                  lip_q, rip_q,
                  lport_q, rport_q, udp_len, 16'h0000};

    assign hdr_idx  = (pos_q < HDR_LEN_L) ? pos_q[5:0] : 6'd0;
    assign hdr_byte = hdr[9'(8 * (HDR_LEN - 1)) - {hdr_idx, 3'b000} +: 8];

    // Address the byte that will be at pos_q next cycle, so the RAM output is always current.
    assign pos_next = out_fire ? pos_q + 11'd1 : pos_q;

    xfcp_udp_tx_buf #(
        .ADDR_WIDTH (BUF_ADDR_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_fire && (state_q == ST_IDLE || state_q == ST_STORE) && (wr_index < MAX_LEN)),
        .wr_addr (BUF_ADDR_WIDTH'(wr_index)),
        .wr_data (s_xfcp.tdata),
        .rd_addr (BUF_ADDR_WIDTH'(pos_next - HDR_LEN_L)),
        .rd_data (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        s_ready       = 1'b0;
        m_valid       = 1'b0;
        m_data        = 8'h00;
        take_snapshot = 1'b0;
        bad_d         = 1'b0;
        over_d        = 1'b0;

        case (state_q)
            ST_IDLE, ST_STORE: begin
                s_ready = run_q;
                if (in_fire) begin
                    state_d = ST_STORE;
                    if (s_xfcp.tlast) begin
                        if (s_xfcp.tuser || !remote_valid) begin
                            bad_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (len_inc > MAX_LEN) begin
                            over_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            take_snapshot = 1'b1;
                            state_d       = ST_CKSUM;
                        end
                    end else if (len_inc > MAX_LEN) begin
                        over_d  = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (in_fire && s_xfcp.tlast) state_d = ST_IDLE;
            end
            ST_CKSUM: begin
                if (cks_step_q) state_d = ST_HDR;
            end
            ST_HDR: begin
                m_valid = 1'b1;
                m_data  = hdr_byte;
                if (out_fire && pos_q == HDR_LEN_L - 11'd1) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                m_valid = 1'b1;
                m_data  = rd_data;
                if (out_fire && pos_q == payload_last)
                    state_d = (pos_q == frame_last) ? ST_IDLE : ST_PAD;
            end
            ST_PAD: begin
                m_valid = 1'b1;
                if (out_fire && pos_q == frame_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_last            = m_valid && (pos_q == frame_last);
    assign s_xfcp.tready     = s_ready;
    assign m_eth_axis.tvalid = m_valid;
    assign m_eth_axis.tdata  = m_data;
    assign m_eth_axis.tlast  = m_last;
    assign m_eth_axis.tuser  = 1'b0;
    assign busy              = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            len_q        <= '0;
            pos_q        <= '0;
            ip_id_q      <= '0;
            sum_q        <= '0;
            csum_q       <= '0;
            cks_step_q   <= 1'b0;
            rmac_q       <= '0;
            lmac_q       <= '0;
            rip_q        <= '0;
            lip_q        <= '0;
            rport_q      <= '0;
            lport_q      <= '0;
            err_bad      <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            err_bad      <= bad_d;
            err_oversize <= over_d;

            if (in_fire && (state_q == ST_IDLE || state_q == ST_STORE)) len_q <= len_inc;

            if (take_snapshot) begin
                rmac_q  <= remote_mac;
                lmac_q  <= local_mac;
                rip_q   <= remote_ip;
                lip_q   <= local_ip;
                rport_q <= remote_port;
                lport_q <= local_port;
            end

            // Two-step checksum: sum the ten header words, then fold twice and invert.
            if (state_q == ST_CKSUM) begin
                cks_step_q <= !cks_step_q;
                pos_q      <= '0;
                if (!cks_step_q)
                    sum_q <= 32'(16'h4500) + 32'(ip_len) + 32'(ip_id_q) + 32'(16'h4000)
                           + 32'({8'(TTL), IP_PROTO_UDP})
                           + 32'(lip_q[31:16]) + 32'(lip_q[15:0])
                           + 32'(rip_q[31:16]) + 32'(rip_q[15:0]);
                else
                    csum_q <= ~ones_fold(ones_fold(sum_q))[15:0];
            end else if (out_fire) begin
                pos_q <= pos_q + 11'd1;
            end

            if (out_fire && m_last) ip_id_q <= ip_id_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_xfcp_udp_tx_framer.sv
// Scoreboard bench: stimulus pushes golden frame bytes, a negedge monitor pops and compares.
module tb_xfcp_udp_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] local_mac  = 48'h02_00_00_00_00_01;
    logic [31:0] local_ip   = 32'hC0A8_0180;
    logic [15:0] local_port = 16'd14000;
    logic [47:0] remote_mac = 48'h02_00_00_00_00_02;
    logic [31:0] remote_ip  = 32'hC0A8_0164;
    logic [15:0] remote_port = 16'd50000;
    logic        remote_valid = 1'b1;
    logic        busy, err_oversize, err_bad;

    xfcp_udp_tx_framer_if s_if();
    xfcp_udp_tx_framer_if m_if();

    xfcp_udp_tx_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_xfcp       (s_if),
        .m_eth_axis   (m_if),
        .local_mac    (local_mac),
        .local_ip     (local_ip),
        .local_port   (local_port),
        .remote_mac   (remote_mac),
        .remote_ip    (remote_ip),
        .remote_port  (remote_port),
        .remote_valid (remote_valid),
        .busy         (busy),
        .err_oversize (err_oversize),
        .err_bad      (err_bad)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pay [2048];
    logic [7:0]  got [2048];
    int          got_n = 0;
    int          first_cyc = 0, last_cyc = 0, tl_cyc = 0;
    int          out_cnt = 0, valid_cnt = 0, bad_cnt = 0, over_cnt = 0;
    bit          ignore_out = 0;
    bit          bp_en = 0;
    logic [15:0] exp_id = 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] g16(input int i);
        return {got[i], got[i+1]};
    endfunction

    // Golden model: build the whole expected frame byte by byte.
    task automatic push_frame(input int n);
        logic [7:0]  h [42];
        logic [15:0] tl, ul;
        int unsigned s;
        int          total;
        tl = 16'(28 + n);
        ul = 16'(8 + n);
        for (int i = 0; i < 6; i++) begin
            h[i]     = remote_mac[47-8*i -: 8];
            h[6+i]   = local_mac[47-8*i -: 8];
        end
        h[12] = 8'h08; h[13] = 8'h00;
        h[14] = 8'h45; h[15] = 8'h00;
        h[16] = tl[15:8]; h[17] = tl[7:0];
        h[18] = exp_id[15:8]; h[19] = exp_id[7:0];
        h[20] = 8'h40; h[21] = 8'h00;
        h[22] = 8'd64; h[23] = 8'h11;
        h[24] = 8'h00; h[25] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            h[26+i] = local_ip[31-8*i -: 8];
            h[30+i] = remote_ip[31-8*i -: 8];
        end
        h[34] = local_port[15:8];  h[35] = local_port[7:0];
        h[36] = remote_port[15:8]; h[37] = remote_port[7:0];
        h[38] = ul[15:8]; h[39] = ul[7:0];
        h[40] = 8'h00; h[41] = 8'h00;
        s = 0;
        for (int i = 0; i < 10; i++) s += {h[14+2*i], h[15+2*i]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        s = ~s;
        h[24] = s[15:8]; h[25] = s[7:0];
        total = (42 + n < 60) ? 60 : 42 + n;
        for (int k = 0; k < total; k++) begin
            logic [7:0] b;
            if (k < 42)          b = h[k];
            else if (k < 42 + n) b = pay[k-42];
            else                 b = 8'h00;
            exp_q.push_back({k == total - 1, b});
        end
        exp_id++;
    endtask

    task automatic send_pkt(input int n, input bit bad);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int t;
            s_if.tdata  = pay[i];
            s_if.tvalid = 1'b1;
            s_if.tlast  = (i == n - 1);
            s_if.tuser  = bad && (i == n - 1);
            acc = 0;
            t = 0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = s_if.tready;
                if (acc && i == n - 1) tl_cyc = cyc;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) check("input_accept_timeout", 64'(t), 64'(0));
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 6000) begin
            @(posedge clk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("busy_after_frame", 64'(busy), 64'(0));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every transferred byte and checks stability through stalls.
    initial begin
        bit         held_v = 0;
        logic [8:0] held = '0;
        forever begin
            @(negedge clk);
            if (err_bad)      bad_cnt++;
            if (err_oversize) over_cnt++;
            if (m_if.tvalid)  valid_cnt++;
            if (rst_n && held_v)
                check("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, held});
            held_v = rst_n && m_if.tvalid && !m_if.tready;
            held   = {m_if.tlast, m_if.tdata};
            if (rst_n && m_if.tvalid && m_if.tready) begin
                out_cnt++;
                if (got_n == 0) first_cyc = cyc;
                if (m_if.tlast) last_cyc = cyc;
                if (got_n < 2048) got[got_n] = m_if.tdata;
                got_n++;
                if (!ignore_out) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {m_if.tlast, m_if.tdata}, 64'h1FF);
                    end else begin
                        logic [8:0] e;
                        e = exp_q.pop_front();
                        check("frame_byte", {m_if.tlast, m_if.tdata}, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: stopped at cycle %0d expected finish before it", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int b0, v0, o0, t;
        s_if.tdata = 8'h00; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;

        #12;
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata",  m_if.tdata, 0);
        check("rst_tlast",  m_if.tlast, 0);
        check("rst_busy",   busy, 0);
        check("rst_errs",   {err_bad, err_oversize}, 0);
        check("rst_tready", s_if.tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_tready", s_if.tready, 1);

        // 4-byte frame with hand-computed header fields.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        got_n = 0;
        push_frame(4);
        send_pkt(4, 0);
        wait_drain();
        check("f4_len",     64'(got_n), 64'd60);
        check("f4_iplen",   g16(16), 16'h0020);
        check("f4_id",      g16(18), 16'h0000);
        check("f4_cksum",   g16(24), 16'hB698);
        check("f4_udplen",  g16(38), 16'h000C);
        check("f4_pad",     {got[46], got[59]}, 16'h0000);
        check("f4_latency", 64'(first_cyc - tl_cyc), 64'd3);

        // 100-byte frame, back-to-back output.
        for (int i = 0; i < 100; i++) pay[i] = 8'(i * 3 + 1);
        got_n = 0;
        push_frame(100);
        send_pkt(100, 0);
        wait_drain();
        check("f100_len",    64'(got_n), 64'd142);
        check("f100_span",   64'(last_cyc - first_cyc), 64'd141);
        check("f100_iplen",  g16(16), 16'h0080);
        check("f100_udplen", g16(38), 16'h006C);
        check("f100_id",     g16(18), 16'h0001);

        // Random backpressure, one padded and one unpadded frame.
        bp_en = 1;
        for (int i = 0; i < 30; i++) pay[i] = 8'($urandom);
        push_frame(30);
        send_pkt(30, 0);
        wait_drain();
        for (int i = 0; i < 7; i++) pay[i] = 8'($urandom);
        push_frame(7);
        send_pkt(7, 0);
        wait_drain();
        bp_en = 0;

        // Oversize drop, then a normal frame.
        v0 = valid_cnt; o0 = over_cnt;
        for (int i = 0; i < 1473; i++) pay[i] = 8'(i);
        send_pkt(1473, 0);
        repeat (4) @(posedge clk);
        #1;
        check("over_pulse",   64'(over_cnt - o0), 64'd1);
        check("over_novalid", 64'(valid_cnt - v0), 64'd0);
        check("over_busy",    busy, 0);
        pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'hC3; pay[3] = 8'h3C;
        push_frame(4);
        send_pkt(4, 0);
        wait_drain();

        // Bad-marked packet and packet with no known remote endpoint.
        v0 = valid_cnt; b0 = bad_cnt;
        send_pkt(5, 1);
        repeat (4) @(posedge clk);
        #1;
        check("bad_tuser_pulse", 64'(bad_cnt - b0), 64'd1);
        check("bad_tuser_busy",  busy, 0);
        remote_valid = 1'b0;
        send_pkt(6, 0);
        repeat (4) @(posedge clk);
        #1;
        remote_valid = 1'b1;
        check("bad_remote_pulse", 64'(bad_cnt - b0), 64'd2);
        check("bad_novalid",      64'(valid_cnt - v0), 64'd0);
        check("bad_busy",         busy, 0);

        // Reset in the middle of a 50-byte payload.
        ignore_out = 1;
        o0 = out_cnt;
        for (int i = 0; i < 50; i++) pay[i] = 8'(8'hF0 ^ i);
        send_pkt(50, 0);
        t = 0;
        while (out_cnt < o0 + 45 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("mid_reached", 64'(out_cnt >= o0 + 45), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_if.tvalid, 0);
        check("mid_rst_busy",   busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ignore_out = 0;
        exp_id = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        got_n = 0;
        push_frame(4);
        send_pkt(4, 0);
        wait_drain();
        check("post_rst_id",  g16(18), 16'h0000);
        check("post_rst_len", 64'(got_n), 64'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xfcp_udp_tx_framer.md
Name: xfcp_udp_tx_framer

Overview:
Transmit-side framer for the XFCP-over-UDP port. Takes one XFCP response packet from the 8-bit XFCP upstream stream and buffers all of it, because IP and UDP lengths must precede the payload. It then emits a complete Ethernet II / IPv4 / UDP frame, without FCS, on an 8-bit AXI stream toward the MAC. The remote endpoint is supplied by the receive side, which captures it from the last valid request.

Parameters:
BUF_ADDR_WIDTH, 11, log2 of payload buffer depth in bytes (2048).
MAX_PAYLOAD, 1472, largest payload in bytes that is framed; longer packets are dropped.
TTL, 64, IPv4 time-to-live field.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
s_xfcp_tdata  in  8  XFCP response byte.
s_xfcp_tvalid  in  1  input byte valid.
s_xfcp_tready  out  1  input byte accepted.
s_xfcp_tlast  in  1  last byte of packet.
s_xfcp_tuser  in  1  packet bad when set with tlast.
m_eth_axis_tdata  out  8  frame byte.
m_eth_axis_tvalid  out  1  frame byte valid.
m_eth_axis_tready  in  1  downstream accepts byte.
m_eth_axis_tlast  out  1  last frame byte.
m_eth_axis_tuser  out  1  always 0.
local_mac  in  48  source MAC.
local_ip  in  32  source IP.
local_port  in  16  source UDP port.
remote_mac  in  48  destination MAC.
remote_ip  in  32  destination IP.
remote_port  in  16  destination UDP port.
remote_valid  in  1  remote endpoint known.
busy  out  1  high in any state except IDLE.
err_oversize  out  1  one-cycle pulse when a packet exceeds MAX_PAYLOAD.
err_bad  out  1  one-cycle pulse when a packet is dropped for tuser=1 or remote_valid=0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. All m_eth_axis_* outputs, busy and both err pulses are 0. s_xfcp_tready=0 during reset, then 1 in IDLE. IP ID counter=0. Buffer pointers and length=0. A frame in progress is abandoned; no partial output resumes after reset.
- States and transitions:
  - IDLE: s_xfcp_tready=1. The first accepted byte is written to buf[0] and the state moves to STORE.
  - STORE: s_xfcp_tready=1. Each accepted byte is written and len increments (len is 11 bits and saturates).
    - On an accepted tlast with tuser=1 or remote_valid=0: pulse err_bad, go to IDLE.
    - On an accepted tlast with len>MAX_PAYLOAD: pulse err_oversize, go to IDLE.
    - Otherwise snapshot remote_*, local_* and len, then go to CKSUM.
    - If len exceeds MAX_PAYLOAD before tlast: pulse err_oversize, go to DROP. Buffer writes stop; the address never wraps.
  - DROP: s_xfcp_tready=1, bytes are discarded. An accepted tlast returns to IDLE.
  - CKSUM: 2 cycles. Compute the IPv4 header ones-complement checksum over 32-bit intermediates, fold twice, invert.
  - HDR: emit 42 header bytes.
  - PAYLOAD: emit len bytes read from the buffer.
  - PAD: emit zero bytes until the frame reaches 60 bytes.
  - After the last byte is accepted: ID counter +1 (wraps at 16 bits), go to IDLE.
- s_xfcp_tready=0 in CKSUM, HDR, PAYLOAD and PAD. There is a single buffer and no overlap between packets.
- Header byte order, all fields big-endian:
  - Ethernet: remote_mac, local_mac, 0x0800.
  - IPv4: 0x45, 0x00, total length=28+len, ID, 0x4000 (DF), TTL, 0x11, checksum, local_ip, remote_ip.
  - UDP: local_port, remote_port, length=8+len, checksum=0x0000.
- Padding applies when 42+len<60 (len<18). IP and UDP lengths exclude the pad.
- Output handshake:
  - tdata, tlast and tvalid hold stable while tvalid=1 and tready=0.
  - A byte advances only on tvalid and tready both high.
  - Buffer reads are prefetched so that tready held high gives one byte per cycle with no bubbles across the HDR→PAYLOAD→PAD boundaries.
- Latency: first header byte is valid on the 3rd cycle after the cycle that accepted the input tlast.
- tlast=1 only on the final byte (the last payload byte, or the last pad byte). tuser=0 always.
- Snapshot fields are frozen; changes to remote_* or local_* during output do not affect the frame in flight.

Decomposition:
- Package xfcp_udp_pkg holds the constants ETH_TYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11, ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, MIN_FRAME_LEN=60, and the state enum typedef.
- One sub-module: xfcp_udp_tx_buf, a simple dual-port byte RAM of 2^BUF_ADDR_WIDTH bytes with a registered read port.

Test Plan:
- 4-byte frame. Stimulus: local_ip=C0A80180, remote_ip=C0A80164, payload 11 22 33 44. Required output: 60 bytes; IP total length 0x0020; ID 0x0000; checksum 0xB698; UDP length 0x000C; 14 zero pad bytes; tlast on byte 60.
- 100-byte frame, tready always high. Required output: 142 contiguous valid bytes with no pad. IP length 0x0080; UDP length 0x006C. The second frame carries ID 0x0001.
- Random tready backpressure at 50%. Required: byte-exact output match against a golden model; tdata stable during every stall.
- Oversize packet of 1473 bytes. Required: err_oversize pulses once; no m_eth_axis_tvalid; a following 4-byte packet is framed correctly.
- Packet ending with tuser=1, and a separate packet sent with remote_valid=0. Required: err_bad pulses once for each; no output; busy returns to 0.
- rst_n asserted mid-PAYLOAD of a 50-byte frame. Required: m_eth_axis_tvalid=0 immediately; after release, a 4-byte packet frames with ID 0x0000.
